// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding, frame length and counter sizing for the PISO sequencer (PISO_TX_PARITY_EN adds a parity bit)
package piso_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

`ifdef PISO_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   function automatic int frame_len(input int n);
      return n + PAR_BITS;
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/piso_shifter.sv
// piso_shifter: N-bit load/shift-left register presenting its MSB as the serial bit
module piso_shifter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         shift_nload,
   input  logic [N-1:0] par_in,
   output logic         serial_out
);

   logic [N-1:0] sh_q, sh_d;

   // hold, shift left with zero fill, or load a fresh word
   always_comb sh_d = !en ? sh_q : shift_nload ? {sh_q[N-2:0], 1'b0} : par_in;

   // shift register state, cleared by reset
   always_ff @(posedge clk or negedge reset)
      if (!reset) sh_q <= '0;
      else        sh_q <= sh_d;

   assign serial_out = sh_q[N-1];

endmodule

// File: rtl/piso_tx_sequencer.sv
// piso_tx_sequencer: valid/ready word intake, MSB-first serialization with frame markers and optional gap (PISO_TX_PARITY_EN appends even parity)
module piso_tx_sequencer
   import piso_pkg::*;
#(
   parameter int N          = 4,
   parameter int GAP_CYCLES = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         ser_out,
   output logic         ser_valid,
   output logic         ser_first,
   output logic         busy,
   output logic         done
);

   localparam int FL = frame_len(N);
   localparam int CW = cnt_width(N);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      gap_q, gap_d;
   logic            accept, last, msb;

   assign last      = (state_q == SHIFT) && (cnt_q == CW'(FL - 1));
   assign in_ready  = (state_q == IDLE) || (last && GAP_CYCLES == 0);
   assign accept    = in_valid && in_ready;
   assign ser_valid = (state_q == SHIFT);
   assign ser_first = ser_valid && (cnt_q == '0);
   assign busy      = (state_q != IDLE);
   assign done      = last;

`ifdef PISO_TX_PARITY_EN
   logic par_q, par_d;

   // parity of the accepted word, captured alongside the load
   always_comb par_d = accept ? ^in_data : par_q;

   // parity register
   always_ff @(posedge clk or negedge reset)
      if (!reset) par_q <= 1'b0;
      else        par_q <= par_d;

   assign ser_out = ser_valid && (last ? par_q : msb);
`else
   assign ser_out = ser_valid && msb;
`endif

   // next state: accept wins, then frame end, then bit and gap counting
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      if (accept) begin
         state_d = SHIFT;
         cnt_d   = '0;
      end else if (last) begin
         state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
         gap_d   = '0;
      end else if (state_q == SHIFT) begin
         cnt_d = cnt_q + 1'b1;
      end else if (state_q == GAP) begin
         gap_d   = gap_q + 4'd1;
         state_d = (gap_q == 4'(GAP_CYCLES - 1)) ? IDLE : GAP;
      end
   end

   // state, bit counter and gap counter registers
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
      end

   piso_shifter #(.N(N)) u_shifter (
      .clk        (clk),
      .reset      (reset),
      .en         (accept || state_q == SHIFT),
      .shift_nload(!accept),
      .par_in     (in_data),
      .serial_out (msb)
   );

endmodule

// File: tb/tb_piso_tx_sequencer.sv
// tb_piso_tx_sequencer: directed table, corner sequences and randomized model check for GAP_CYCLES 0 and 2
module tb_piso_tx_sequencer;

`ifdef PISO_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int N  = 4;
   localparam int FL = N + PAR;

   logic clk = 0, reset = 0, in_valid = 0;
   logic [N-1:0] in_data = '0;
   logic r0, o0, v0, f0, b0, d0, r1, o1, v1, f1, b1, d1;
   logic rdy, so, sv, sf, bs, dn;
   int   sel = 0, checks = 0, errors = 0;

   always #5 clk = ~clk;

   piso_tx_sequencer #(.N(N), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
      .ser_out(o0), .ser_valid(v0), .ser_first(f0), .busy(b0), .done(d0));

   piso_tx_sequencer #(.N(N), .GAP_CYCLES(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
      .ser_out(o1), .ser_valid(v1), .ser_first(f1), .busy(b1), .done(d1));

   always_comb begin
      rdy = sel ? r1 : r0;
      so  = sel ? o1 : o0;
      sv  = sel ? v1 : v0;
      sf  = sel ? f1 : f0;
      bs  = sel ? b1 : b0;
      dn  = sel ? d1 : d0;
   end

   typedef struct {
      logic         v;
      logic [N-1:0] d;
      logic [5:0]   exp;
   } vec_t;

   vec_t tbl[$];
   logic [2:0] mq[$];
   int gap_left;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [N-1:0] d, input logic [5:0] e);
      vec_t t;
      t.v = v; t.d = d; t.exp = e;
      tbl.push_back(t);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 0; in_valid = 0;
      #1;
      chk("reset_outs", {so, sv, sf, bs, dn}, 5'b0);
      @(negedge clk);
      reset = 1;
      #1;
      chk("release_rdy_sv", {rdy, sv}, 2'b10);
   endtask

   function automatic logic [5:0] outs();
      return {rdy, sv, so, sf, dn, bs};
   endfunction

   initial begin
      logic [N-1:0] w;
      logic [2:0]   p;
      logic         m_rdy, acc;
      int           g;
      // {rdy, ser_valid, ser_out, ser_first, done, busy}
`ifdef PISO_TX_PARITY_EN
      add(1, 4'hB, 6'b100000); add(1, 4'h6, 6'b011101); add(0, 4'h0, 6'b010001);
      add(0, 4'h0, 6'b011001); add(1, 4'h6, 6'b011001); add(1, 4'h6, 6'b111011);
      add(0, 4'h0, 6'b010101); add(0, 4'h0, 6'b011001); add(0, 4'h0, 6'b011001);
      add(0, 4'h0, 6'b010001); add(0, 4'h0, 6'b110011); add(0, 4'h0, 6'b100000);
      add(1, 4'h9, 6'b100000); add(0, 4'h0, 6'b011101); add(0, 4'h0, 6'b010001);
      add(0, 4'h0, 6'b010001); add(0, 4'h0, 6'b011001); add(0, 4'h0, 6'b110011);
`else
      add(1, 4'hB, 6'b100000); add(1, 4'h6, 6'b011101); add(0, 4'h0, 6'b010001);
      add(0, 4'h0, 6'b011001); add(1, 4'h6, 6'b111011); add(0, 4'h0, 6'b010101);
      add(0, 4'h0, 6'b011001); add(0, 4'h0, 6'b011001); add(0, 4'h0, 6'b110011);
      add(0, 4'h0, 6'b100000);
`endif
      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         in_valid = tbl[i].v; in_data = tbl[i].d;
         chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end

      // mid-frame reset after two bits, then a clean frame
      @(negedge clk); in_valid = 1; in_data = 4'hB;
      @(negedge clk); in_valid = 0;
      @(negedge clk);
      reset = 0;
      #1 chk("midreset_outs", {so, sv, sf, bs, dn}, 5'b0);
      @(negedge clk); reset = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_abort_idle", outs(), 6'b100000);
      end
      in_valid = 1; in_data = 4'h1;
      w = 4'h1;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk); in_valid = 0;
         chk($sformatf("clean_bit%0d", i), {sv, so, sf, dn},
             {1'b1, (i < N) ? w[N-1-i] : ^w, i == 0, i == FL - 1});
      end
      @(negedge clk); chk("clean_idle", outs(), 6'b100000);

      // gap instance: two queued words with in_valid held
      sel = 1;
      do_reset();
      @(negedge clk); in_valid = 1; in_data = 4'hB;
      chk("gap_idle_rdy", outs(), 6'b100000);
      for (int i = 0; i < FL; i++) begin
         @(negedge clk); in_data = 4'h6;
         chk($sformatf("gap_f1_bit%0d", i), {rdy, sv, dn}, {2'b01, i == FL - 1});
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("gap_cycle%0d", i), {rdy, sv, so, bs}, 4'b0001);
      end
      @(negedge clk); chk("gap_then_idle", outs(), 6'b100000);
      @(negedge clk); in_valid = 0;
      chk("gap_f2_first", {sv, so, sf}, 3'b101);

      // randomized run against a bit-queue model, for each gap setting
      for (int s = 0; s < 2; s++) begin
         sel = s; g = s ? 2 : 0;
         do_reset();
         mq.delete(); gap_left = 0;
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            m_rdy = (mq.size() == 0 && gap_left == 0) || (mq.size() == 1 && g == 0);
            p = (mq.size() > 0) ? mq[0] : 3'b000;
            chk($sformatf("rand_s%0d_c%0d", s, c), outs(),
                {m_rdy, mq.size() > 0, p[2], p[1], p[0], mq.size() > 0 || gap_left > 0});
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = N'($urandom);
            acc = in_valid && m_rdy;
            if (mq.size() > 0) begin
               p = mq.pop_front();
               if (p[0] && g > 0) gap_left = g;
            end else if (gap_left > 0) gap_left--;
            if (acc) begin
               for (int i = N - 1; i >= 0; i--)
                  mq.push_back({in_data[i], i == N - 1, i == 0 && PAR == 0});
               if (PAR == 1) mq.push_back({^in_data, 1'b0, 1'b1});
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
